// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch and data ports of the core.
// Data accesses win unless a pending fetch has already been passed over MAX_WAIT times in a row.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy
);

  localparam logic [3:0] StreakMax = 4'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StIXfer, StDXfer, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              data_wins;

  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    data_wins = d_req && !(i_req && (streak_q == StreakMax));

    unique case (state_q)
      StIdle: begin
        if (data_wins) begin
          state_d   = StDXfer;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          // Only data grants that overtake a waiting fetch count toward starvation.
          if (i_req) begin
            streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 4'd1;
          end else begin
            streak_d = '0;
          end
        end else if (i_req) begin
          state_d  = StIXfer;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = i_addr;
          streak_d = '0;
        end
      end
      StIXfer: begin
        if (m_ack) begin
          state_d   = StDone;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          i_ack_d   = 1'b1;
          i_rdata_d = m_rdata;
        end
      end
      StDXfer: begin
        if (m_ack) begin
          state_d = StDone;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          d_ack_d = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      // Ack is visible here; no arbitration so a requester still holding its line is not regranted.
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      streak_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences, and a randomized
// phase checked against a golden word memory and the fetch-starvation bound.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic          clk, rst;
  logic          i_req, i_ack;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ack;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          busy;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_ack(m_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  // Memory word array seen by the responder; golden is the bench's view of what it should hold.
  logic [DW-1:0] mem    [64];
  logic [DW-1:0] golden [64];
  int unsigned   mem_wait = 0;
  bit            rand_wait = 1'b0;
  bit            mem_active = 1'b0;
  int unsigned   cur_wait = 0;
  int unsigned   wcnt = 0;

  // Memory responder: acks after cur_wait extra cycles of m_req being high.
  always @(negedge clk) begin
    if (!m_req || m_ack) begin
      m_ack = 1'b0;
      mem_active = 1'b0;
      wcnt = 0;
    end else begin
      if (!mem_active) begin
        mem_active = 1'b1;
        cur_wait = rand_wait ? $urandom_range(0, 3) : mem_wait;
      end
      if (wcnt >= cur_wait) begin
        m_ack = 1'b1;
        if (m_we) begin
          mem[m_addr[7:2]] = m_wdata;
          m_rdata = $urandom;
        end else begin
          m_rdata = mem[m_addr[7:2]];
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned nwait;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t          vecs [7];
  vec_t          t;
  int            req_cyc, td, ti, n, i_age, i_dcnt;
  bit            fld_bad, other, got, issue;
  logic [DW-1:0] rdata, last_d;
  bit            order [10];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h40, 32'h12345678, 3, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h40, 32'h0,        1, 32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 32'h40, 32'h0,        2, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 32'h10, 32'h0,        0, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 1'b1, 32'h3C, 32'hCAFEF00D, 0, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 1'b0, 32'h3C, 32'h0,        0, 32'hCAFEF00D};

    for (int k = 0; k < 64; k++) begin
      mem[k] = 32'h5A000000 | (k * 32'h0101);
      golden[k] = mem[k];
    end
    mem[4] = 32'hDEADBEEF;
    golden[4] = 32'hDEADBEEF;

    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_ack = 1'b0; m_rdata = '0;
    #2 rst = 1'b0;
    #1;
    check("reset_ctrl", {27'b0, m_req, m_we, i_ack, d_ack, busy}, 32'h0);
    check("reset_m_addr", m_addr, 32'h0);
    check("reset_rdata", i_rdata | d_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_release_idle", {30'b0, m_req, busy}, 32'h0);

    // Directed single transactions.
    for (int v = 0; v < 7; v++) begin
      t = vecs[v];
      mem_wait = t.nwait;
      @(negedge clk);
      if (t.fetch) begin
        i_req = 1'b1; i_addr = t.addr;
      end else begin
        d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
      end
      req_cyc = 0; fld_bad = 1'b0; other = 1'b0; got = 1'b0; rdata = '0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        if (m_req) begin
          req_cyc++;
          if (m_addr !== t.addr || m_we !== (t.we && !t.fetch) ||
              (!t.fetch && t.we && m_wdata !== t.wdata)) fld_bad = 1'b1;
        end
        if (t.fetch ? d_ack : i_ack) other = 1'b1;
        if (t.fetch ? i_ack : d_ack) begin
          got = 1'b1;
          rdata = t.fetch ? i_rdata : d_rdata;
        end
      end
      i_req = 1'b0; d_req = 1'b0;
      if (!t.fetch && t.we) golden[t.addr[7:2]] = t.wdata;
      check($sformatf("vec%0d_ack_seen", v), {31'b0, got}, 32'h1);
      check($sformatf("vec%0d_m_req_cycles", v), req_cyc, t.nwait + 1);
      check($sformatf("vec%0d_m_fields", v), {31'b0, fld_bad}, 32'h0);
      check($sformatf("vec%0d_other_ack", v), {31'b0, other}, 32'h0);
      check($sformatf("vec%0d_rdata", v), rdata, t.exp_rdata);
      @(negedge clk);
      check($sformatf("vec%0d_idle_after_done", v), {28'b0, m_req, busy, i_ack, d_ack}, 32'h0);
      @(negedge clk);
      check($sformatf("vec%0d_no_regrant", v), {30'b0, m_req, busy}, 32'h0);
    end

    // Reset in the middle of a data transfer.
    mem_wait = 10;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hA5A5A5A5;
    for (int c = 0; c < 10 && !m_req; c++) @(negedge clk);
    check("midxfer_m_req_up", {31'b0, m_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("midxfer_reset_ctrl", {27'b0, m_req, m_we, i_ack, d_ack, busy}, 32'h0);
    check("midxfer_reset_addr_wdata", m_addr | m_wdata, 32'h0);
    check("midxfer_reset_rdata", i_rdata | d_rdata, 32'h0);
    d_req = 1'b0;
    mem_wait = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midxfer_release_idle", {30'b0, m_req, busy}, 32'h0);

    // Starvation: both ports request continuously; fetch must win after MW data grants.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    i_req = 1'b1; i_addr = 32'h20;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if (i_ack) begin order[n] = 1'b1; n++; end
      else if (d_ack) begin order[n] = 1'b0; n++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("starve_count", n, 10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("starve_grant%0d", k), {31'b0, order[k]},
            {31'b0, ((k % (MW + 1)) == MW)});
    end
    repeat (3) @(negedge clk);

    // Simultaneous requests: data first, fetch at least 3 cycles later.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    i_req = 1'b1; i_addr = 32'h3C;
    td = -1; ti = -1;
    for (int c = 0; c < 100 && ti < 0; c++) begin
      @(negedge clk);
      if (d_ack && td < 0) begin td = c; d_req = 1'b0; end
      if (i_ack && ti < 0) begin ti = c; i_req = 1'b0; end
    end
    d_req = 1'b0; i_req = 1'b0;
    check("simul_both_acked", {30'b0, (td >= 0), (ti >= 0)}, 32'h3);
    check("simul_data_first", {31'b0, (ti > td)}, 32'h1);
    check("simul_gap", {31'b0, (ti - td >= 3)}, 32'h1);
    repeat (3) @(negedge clk);

    // Randomized traffic against the golden memory.
    rand_wait = 1'b1;
    last_d = golden[4];
    i_age = 0; i_dcnt = 0;
    for (int c = 0; c < 2200; c++) begin
      @(negedge clk);
      issue = (c < 2000);
      check("rnd_ack_exclusive", {31'b0, i_ack & d_ack}, 32'h0);
      if (i_ack) begin
        check("rnd_i_ack_has_req", {31'b0, i_req}, 32'h1);
        check("rnd_fetch_data", i_rdata, golden[i_addr[7:2]]);
        check("rnd_starve_bound", {31'b0, (i_dcnt <= MW + 1)}, 32'h1);
        i_req = 1'b0; i_dcnt = 0; i_age = 0;
      end else if (i_req) begin
        i_age++;
        if (d_ack) i_dcnt++;
      end else if (issue && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (d_ack) begin
        check("rnd_d_ack_has_req", {31'b0, d_req}, 32'h1);
        if (d_we) begin
          check("rnd_write_keeps_rdata", d_rdata, last_d);
          golden[d_addr[7:2]] = d_wdata;
        end else begin
          check("rnd_read_data", d_rdata, golden[d_addr[7:2]]);
          last_d = golden[d_addr[7:2]];
        end
        d_req = 1'b0;
      end else if (!d_req && issue && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 63)) << 2;
        d_wdata = $urandom;
      end
    end
    check("rnd_drained", {30'b0, i_req, d_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one external single-ported memory between the core's instruction-fetch port and data port, so a unified program/data memory can replace the split instruction and data memories. The block sits between `core` and the memory controller. Each core port gets a request/acknowledge interface, and the memory side gets a held-request/acknowledge interface. Data accesses have priority, and a starvation limit guarantees fetch progress.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `MAX_WAIT`, 4, maximum consecutive data grants while a fetch is pending; range 1–15

- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `i_req`  in  1  fetch request; held with `i_addr` stable until `i_ack`
- `i_addr`  in  ADDR_W  fetch byte address
- `i_rdata`  out  DATA_W  fetched word; valid while `i_ack`=1, held until the next fetch completes
- `i_ack`  out  1  one-cycle fetch-complete pulse
- `d_req`  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` stable until `d_ack`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data byte address
- `d_wdata`  in  DATA_W  write data
- `d_rdata`  out  DATA_W  read word; updated on read completion only
- `d_ack`  out  1  one-cycle data-complete pulse
- `m_req`  out  1  memory request; held until `m_ack` is sampled
- `m_we`  out  1  memory write enable
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rdata`  in  DATA_W  memory read data; valid when `m_ack`=1
- `m_ack`  in  1  one-cycle completion from memory
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- **FSM states:** IDLE, I_XFER, D_XFER, DONE.
- **IDLE:**
  - If `d_req`=1 and the priority rule selects data, go to D_XFER.
  - Otherwise, if `i_req`=1, go to I_XFER.
  - Otherwise, stay in IDLE.
- **Priority rule:**
  - Data wins unless `i_req`=1 and `streak`==`MAX_WAIT`; in that case the fetch wins.
  - `streak` is a 4-bit counter. It increments on a data grant made while `i_req`=1.
  - It clears on any fetch grant, and on a data grant made while `i_req`=0.
  - It saturates at `MAX_WAIT`.
- **On grant:**
  - `m_addr` and `m_req`=1 are registered from the winner's fields.
  - `m_we` and `m_wdata` come from `d_we` and `d_wdata` for a data grant; `m_we`=0 for a fetch grant.
- **I_XFER / D_XFER:** hold all `m_*` outputs stable until `m_ack`=1 is sampled, then go to DONE.
  - `m_req`, `m_we` → 0.
  - The winner's ack is set to 1.
  - `i_rdata` captures `m_rdata` on a fetch; `d_rdata` captures it on a data read. `d_rdata` is unchanged on a write.
- **DONE:** lasts one cycle. The ack is visible here; no arbitration happens, so a stale request cannot be granted again. Then go to IDLE and clear the ack.
- `m_addr` and `m_wdata` keep their last values when idle.
- **Reset:** asynchronous assertion at any time forces IDLE and clears `streak`. All outputs go to 0, including `i_rdata` and `d_rdata`.
  - An in-flight memory transaction is abandoned; the memory side must tolerate `m_req` dropping.

## Timing
- Every output is registered. There is no combinational path from inputs to outputs.
- **Access latency:**
  - The request is sampled at edge N and `m_req` is high after edge N.
  - `m_ack` is sampled at edge N+1+W, where W ≥ 0 is the number of memory wait cycles.
  - The ack is high during the cycle after edge N+1+W.
  - The arbiter is back in IDLE after edge N+2+W.
- **Zero-wait throughput:** one access every 3 cycles (IDLE, XFER, DONE).
- **Simultaneous requests** in IDLE: exactly one grant; the loser's request stays pending with no ack.
- `m_ack` outside I_XFER/D_XFER is ignored.
- Requests arriving while `busy`=1 wait; they are never dropped.
- `i_ack` and `d_ack` are never high in the same cycle.

## Test plan
- **Reset values:** assert `rst`=0 mid-D_XFER with `m_req`=1. Required: outputs 0 asynchronously, before the next edge. After release with no request: IDLE, `busy`=0.
- **Zero-wait fetch:** `i_addr`=0x10, memory acks in the first `m_req` cycle with `m_rdata`=0xDEADBEEF. Required: `m_req` high exactly 1 cycle with `m_addr`=0x10 and `m_we`=0; `i_ack` pulse 1 cycle with `i_rdata`=0xDEADBEEF.
- **Data write with 3 wait cycles:** `d_we`=1, `d_addr`=0x40, `d_wdata`=0x12345678. Required: `m_req` held 4 cycles with stable fields; one `d_ack` pulse; `d_rdata` unchanged; `i_ack` not asserted.
- **Simultaneous request:** `i_req` and `d_req` in the same cycle. Required: data served first. `i_ack` occurs after `d_ack` and no earlier than 3 cycles after it, zero-wait.
- **Starvation:** `d_req` held continuously and `i_req` held, `MAX_WAIT`=4. Required: grant order D,D,D,D,I,D,D,D,D,I; no fetch waits more than 4 data accesses.
- **No double grant:** requester holds `i_req` high during its `i_ack` cycle, then drops it. Required: exactly one memory transaction per request; `m_req` stays low after the DONE cycle.
